// File: rtl/butterfly_gather_collector_pkg.sv
// Shared constants and helpers for the butterfly gather collector: default lane
// geometry, {seq, data} payload packing offsets and the sequence-number increment.
package butterfly_gather_collector_pkg;

    localparam int DEF_NETWORK_WIDTH_LOG2 = 3;
    localparam int DEF_N                  = 1 << DEF_NETWORK_WIDTH_LOG2;
    localparam int DEF_W                  = 8;
    localparam int DEF_SEQ_W              = 4;
    localparam int DEF_LANE_DEPTH         = 4;
    localparam int DEF_EXP_DEPTH          = 4;
    localparam int DEF_PAYLOAD_W          = DEF_W + DEF_SEQ_W;
    localparam int DEF_DATA_LSB           = 0;

    // Lane payload is packed {seq, data}: data in the low bits, tag above it.
    function automatic int payload_width(input int w, input int seq_w);
        return w + seq_w;
    endfunction

    function automatic int seq_offset(input int w);
        return w;
    endfunction

    function automatic int unsigned seq_inc(input int unsigned s, input int unsigned seq_w);
        return (s + 32'd1) & ((32'd1 << seq_w) - 32'd1);
    endfunction

endpackage

// File: rtl/butterfly_gather_collector_lane_fifo.sv
// gather_lane_fifo: first-word-fall-through synchronous FIFO with full/empty,
// used for every network lane and for the expectation queue.
module gather_lane_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/butterfly_gather_collector.sv
// Receive endpoint of the butterfly network: buffers per-lane traffic and reassembles
// beats in expectation order. Define BUTTERFLY_GATHER_SEQ_CHECK_EN for sequence-tag checking.
module butterfly_gather_collector
    import butterfly_gather_collector_pkg::*;
#(
    parameter int  NETWORK_WIDTH_LOG2 = DEF_NETWORK_WIDTH_LOG2,
    parameter int  W                  = DEF_W,
    parameter int  SEQ_W              = DEF_SEQ_W,
    parameter int  LANE_DEPTH         = DEF_LANE_DEPTH,
    parameter int  EXP_DEPTH          = DEF_EXP_DEPTH,
    localparam int N                  = 1 << NETWORK_WIDTH_LOG2,
    localparam int PW                 = payload_width(W, SEQ_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       net_valid_vec,
    input  logic [PW*N-1:0]    net_payload_vec,
    output logic [N-1:0]       net_ready_vec,
    input  logic               exp_valid,
    input  logic [N-1:0]       exp_mask,
    output logic               exp_ready,
    output logic               out_valid,
    output logic [N-1:0]       out_mask,
    output logic [W*N-1:0]     out_data_vec,
    output logic [SEQ_W-1:0]   out_seq,
    input  logic               out_ready,
    output logic               err_seq,
    output logic [N-1:0]       err_lane
);

    localparam int SEQ_LSB  = seq_offset(W);
    localparam int DATA_LSB = DEF_DATA_LSB;

    logic [PW-1:0]    lane_dout [N];
    logic [N-1:0]     lane_full, lane_empty, lane_pop, lane_ok;
    logic [W*N-1:0]   load_data;
    logic [N-1:0]     exp_head;
    logic             exp_full, exp_empty, complete, load;

    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     out_mask_q, out_mask_d;
    logic [W*N-1:0]   out_data_q, out_data_d;
    logic [SEQ_W-1:0] out_seq_q, out_seq_d;
    logic [SEQ_W-1:0] cur_seq_q, cur_seq_d;

`ifdef BUTTERFLY_GATHER_SEQ_CHECK_EN
    logic [N-1:0]     lane_mis;
`else
    logic [N-1:0]     unused_lane_seq;
`endif

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        gather_lane_fifo #(.WIDTH(PW), .DEPTH(LANE_DEPTH)) u_lane_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (net_valid_vec[gi]),
            .din_i   (net_payload_vec[gi*PW +: PW]),
            .pop_i   (lane_pop[gi]),
            .dout_o  (lane_dout[gi]),
            .full_o  (lane_full[gi]),
            .empty_o (lane_empty[gi])
        );
        assign net_ready_vec[gi]       = !lane_full[gi];
        assign lane_ok[gi]             = !exp_head[gi] || !lane_empty[gi];
        assign lane_pop[gi]            = load && exp_head[gi];
        assign load_data[gi*W +: W]    = exp_head[gi] ? lane_dout[gi][DATA_LSB +: W] : '0;
`ifdef BUTTERFLY_GATHER_SEQ_CHECK_EN
        assign lane_mis[gi] = exp_head[gi] && (lane_dout[gi][SEQ_LSB +: SEQ_W] != cur_seq_q);
`else
        assign unused_lane_seq[gi] = ^lane_dout[gi][SEQ_LSB +: SEQ_W];
`endif
    end

    gather_lane_fifo #(.WIDTH(N), .DEPTH(EXP_DEPTH)) u_exp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (exp_valid),
        .din_i   (exp_mask),
        .pop_i   (load),
        .dout_o  (exp_head),
        .full_o  (exp_full),
        .empty_o (exp_empty)
    );

    assign exp_ready = !exp_full;
    // An all-zero head mask satisfies &lane_ok trivially and emits an empty beat.
    assign complete  = !exp_empty && (&lane_ok);
    assign load      = complete && (!out_valid_q || out_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_mask_d  = out_mask_q;
        out_data_d  = out_data_q;
        out_seq_d   = out_seq_q;
        cur_seq_d   = cur_seq_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_mask_d  = exp_head;
            out_data_d  = load_data;
            out_seq_d   = cur_seq_q;
            cur_seq_d   = SEQ_W'(seq_inc(32'(cur_seq_q), SEQ_W));
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_data_q  <= '0;
            out_seq_q   <= '0;
            cur_seq_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
            out_data_q  <= out_data_d;
            out_seq_q   <= out_seq_d;
            cur_seq_q   <= cur_seq_d;
        end
    end

`ifdef BUTTERFLY_GATHER_SEQ_CHECK_EN
    logic         err_seq_q, err_seq_d;
    logic [N-1:0] err_lane_q, err_lane_d;

    assign err_lane_d = err_lane_q | (load ? lane_mis : '0);
    assign err_seq_d  = err_seq_q | (load && (|lane_mis));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_seq_q  <= 1'b0;
            err_lane_q <= '0;
        end else begin
            err_seq_q  <= err_seq_d;
            err_lane_q <= err_lane_d;
        end
    end

    assign err_seq  = err_seq_q;
    assign err_lane = err_lane_q;
`else
    assign err_seq  = 1'b0;
    assign err_lane = '0;
`endif

    assign out_valid    = out_valid_q;
    assign out_mask     = out_mask_q;
    assign out_data_vec = out_data_q;
    assign out_seq      = out_seq_q;

endmodule

// File: tb/tb_butterfly_gather_collector.sv
// Self-checking bench for butterfly_gather_collector: table-driven beats plus directed
// corner sequences, all checked against a beat scoreboard.
module tb_butterfly_gather_collector;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 4;
    localparam int PW = W + SW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      net_valid_vec = '0;
    logic [PW*N-1:0]   net_payload_vec = '0;
    logic [N-1:0]      net_ready_vec;
    logic              exp_valid = 1'b0;
    logic [N-1:0]      exp_mask = '0;
    logic              exp_ready;
    logic              out_valid;
    logic [N-1:0]      out_mask;
    logic [W*N-1:0]    out_data_vec;
    logic [SW-1:0]     out_seq;
    logic              out_ready = 1'b1;
    logic              err_seq;
    logic [N-1:0]      err_lane;

    typedef struct {
        logic [7:0]  mask;
        logic [63:0] data;
        logic [63:0] exp_data;
    } vec_t;

    typedef struct {
        logic [7:0]  mask;
        logic [63:0] data;
        logic [3:0]  seq;
    } beat_t;

    beat_t      sb[$];
    logic [3:0] model_seq = '0;
    int         tests = 0;
    int         fails = 0;
    vec_t       tbl[5];

`ifdef BUTTERFLY_GATHER_SEQ_CHECK_EN
    localparam logic [7:0] T5_ERR_LANE = 8'h04;
    localparam logic       T5_ERR_SEQ  = 1'b1;
`else
    localparam logic [7:0] T5_ERR_LANE = 8'h00;
    localparam logic       T5_ERR_SEQ  = 1'b0;
`endif

    butterfly_gather_collector #(
        .NETWORK_WIDTH_LOG2(3), .W(W), .SEQ_W(SW), .LANE_DEPTH(4), .EXP_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .net_valid_vec(net_valid_vec), .net_payload_vec(net_payload_vec),
        .net_ready_vec(net_ready_vec),
        .exp_valid(exp_valid), .exp_mask(exp_mask), .exp_ready(exp_ready),
        .out_valid(out_valid), .out_mask(out_mask), .out_data_vec(out_data_vec),
        .out_seq(out_seq), .out_ready(out_ready),
        .err_seq(err_seq), .err_lane(err_lane)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected beat; lanes are driven separately by push_lanes.
    task automatic push_exp(input logic [7:0] m, input logic [63:0] expd);
        int   budget = 200;
        logic acc = 1'b0;
        sb.push_back('{m, expd, model_seq});
        model_seq++;
        exp_valid = 1'b1;
        exp_mask  = m;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = exp_ready;
            tick();
            budget--;
        end
        exp_valid = 1'b0;
        if (!acc) check("exp_push_timeout", 64'd0, 64'd1);
    endtask

    task automatic push_lanes(input logic [7:0] m, input logic [63:0] d, input logic [3:0] s);
        logic [7:0] pending = m;
        logic [7:0] acc;
        int         budget = 200;
        for (int i = 0; i < N; i++) net_payload_vec[i*PW +: PW] = {s, d[i*W +: W]};
        while (pending != 0 && budget > 0) begin
            net_valid_vec = pending;
            @(negedge clk);
            acc = pending & net_ready_vec;
            tick();
            pending &= ~acc;
            budget--;
        end
        net_valid_vec = '0;
        if (pending != 0) check("lane_push_timeout", 64'(pending), 64'd0);
    endtask

    task automatic do_reset();
        repeat (6) tick();
        check("drain_before_reset", 64'(sb.size()), 64'd0);
        rst_n = 1'b0;
        sb.delete();
        model_seq = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Scoreboard monitor, plus a stability check on every stalled output cycle.
    initial begin
        beat_t e;
        beat_t held;
        logic  held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_mask", 64'(out_mask), 64'(held.mask));
                    check("hold_data", out_data_vec, held.data);
                    check("hold_seq", 64'(out_seq), 64'(held.seq));
                end
                if (out_valid && out_ready) begin
                    held_v = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 64'(out_seq), 64'hFFFF);
                    end else begin
                        e = sb.pop_front();
                        $display("[TB] beat seq=%0d mask=%02h data=%016h", out_seq, out_mask, out_data_vec);
                        check("beat_mask", 64'(out_mask), 64'(e.mask));
                        check("beat_data", out_data_vec, e.data);
                        check("beat_seq", 64'(out_seq), 64'(e.seq));
                    end
                end else if (out_valid) begin
                    held_v = 1'b1;
                    held   = '{out_mask, out_data_vec, out_seq};
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [3:0]  s;
        logic [63:0] d;

        tbl[0] = '{8'hA5, 64'h8877665544332211, 64'h8800660000330011};
        tbl[1] = '{8'hFF, 64'h0102030405060708, 64'h0102030405060708};
        tbl[2] = '{8'h0F, 64'hF0E0D0C0B0A09080, 64'h00000000B0A09080};
        tbl[3] = '{8'h80, 64'h0123456789ABCDEF, 64'h0100000000000000};
        tbl[4] = '{8'h3C, 64'hDEADBEEFCAFEF00D, 64'h0000BEEFCAFE0000};

        // Reset values (checked while reset is held)
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_mask", 64'(out_mask), 64'd0);
        check("rst_out_data", out_data_vec, 64'd0);
        check("rst_out_seq", 64'(out_seq), 64'd0);
        check("rst_err_seq", 64'(err_seq), 64'd0);
        check("rst_err_lane", 64'(err_lane), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_net_ready", 64'(net_ready_vec), 64'hFF);
        check("idle_exp_ready", 64'(exp_ready), 64'd1);

        // Full-width beat, lanes arrive in reverse order
        push_exp(8'hFF, 64'h1716151413121110);
        for (int i = N - 1; i >= 0; i--) begin
            d = 64'(8'h10 + i) << (i * W);
            push_lanes(8'(1 << i), d, 4'd0);
        end
        @(negedge clk);
        check("t1_latency_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_latency_c2", 64'(out_valid), 64'd1);
        tick();

        // Empty-mask beats consume sequence numbers
        do_reset();
        push_exp(8'h00, 64'd0);
        @(negedge clk);
        check("t3_latency_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t3_latency_c2", 64'(out_valid), 64'd1);
        tick();
        push_exp(8'h00, 64'd0);

        // Table-driven beats, back to back
        do_reset();
        for (int k = 0; k < 5; k++) begin
            s = model_seq;
            push_exp(tbl[k].mask, tbl[k].exp_data);
            push_lanes(tbl[k].mask, tbl[k].data, s);
        end

        // Lane 1 arrives early and must wait for the second beat
        do_reset();
        push_exp(8'h01, 64'h00000000000000A0);
        push_exp(8'h03, 64'h000000000000B1A1);
        push_lanes(8'h02, 64'h000000000000B100, 4'd1);
        repeat (2) tick();
        check("t2_lane1_held", 64'(out_valid), 64'd0);
        push_lanes(8'h01, 64'h00000000000000A0, 4'd0);
        push_lanes(8'h01, 64'h00000000000000A1, 4'd1);

        // Lane 3 fills while the output is stalled
        do_reset();
        out_ready = 1'b0;
        push_exp(8'h00, 64'd0);
        for (int k = 0; k < 4; k++) begin
            check("t4_ready_before_push", 64'(net_ready_vec[3]), 64'd1);
            push_lanes(8'h08, 64'(8'hC0 + k) << 24, 4'(k + 1));
        end
        check("t4_ready_full", 64'(net_ready_vec[3]), 64'd0);
        fork
            push_lanes(8'h08, 64'(8'hC4) << 24, 4'd5);
            begin
                repeat (3) tick();
                check("t4_still_full", 64'(net_ready_vec[3]), 64'd0);
                check("t4_stalled_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
                for (int k = 0; k < 5; k++) push_exp(8'h08, 64'(8'hC0 + k) << 24);
            end
        join
        repeat (6) tick();
        check("t4_err_clean", 64'(err_lane), 64'd0);

        // Sequence tag mismatch on lane 2
        do_reset();
        push_exp(8'h04, 64'h0000000000770000);
        push_lanes(8'h04, 64'h0000000000770000, 4'd5);
        repeat (3) tick();
        check("t5_err_lane", 64'(err_lane), 64'(T5_ERR_LANE));
        check("t5_err_seq", 64'(err_seq), 64'(T5_ERR_SEQ));
        repeat (5) tick();
        check("t5_err_lane_sticky", 64'(err_lane), 64'(T5_ERR_LANE));
        check("t5_err_seq_sticky", 64'(err_seq), 64'(T5_ERR_SEQ));

        // Asynchronous reset with data buffered and a beat held
        do_reset();
        out_ready = 1'b0;
        push_lanes(8'h01, 64'h00000000000000E1, 4'd0);
        push_lanes(8'h01, 64'h00000000000000E2, 4'd1);
        push_lanes(8'h01, 64'h00000000000000E3, 4'd2);
        push_exp(8'h01, 64'h00000000000000E1);
        repeat (2) tick();
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        model_seq = '0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_mask", 64'(out_mask), 64'd0);
        check("t6_rst_data", out_data_vec, 64'd0);
        check("t6_rst_seq", 64'(out_seq), 64'd0);
        check("t6_rst_err_seq", 64'(err_seq), 64'd0);
        check("t6_rst_err_lane", 64'(err_lane), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        push_exp(8'h01, 64'h000000000000005A);
        push_lanes(8'h01, 64'h000000000000005A, 4'd0);

        repeat (8) tick();
        check("final_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/butterfly_gather_collector.md
# butterfly_gather_collector

- Receive-side endpoint of the buffered butterfly network.
- Accepts per-lane traffic from the network output channels, buffers it per lane, and reassembles the original multi-lane beats in issue order.
- Issue order and membership come from an expectation stream supplied by the dispatch side.
- Emits one aligned wide beat per expectation entry to the downstream consumer.

## Interface
- NETWORK_WIDTH_LOG2, 3, log2 of lane count N.
- W, 8, data bits per lane (excluding sequence tag).
- SEQ_W, 4, beat sequence tag width carried in each lane payload.
- LANE_DEPTH, 4, entries per lane FIFO (power of two, ≥2).
- EXP_DEPTH, 4, entries in expectation FIFO (power of two, ≥2).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- net_valid_vec  in  N  per-lane valid from network outputs.
- net_payload_vec  in  (W+SEQ_W)*N  lane i at [i*(W+SEQ_W) +: W+SEQ_W], packed {seq, data}.
- net_ready_vec  out  N  per-lane ready to network.
- exp_valid  in  1  expectation entry valid.
- exp_mask  in  N  lanes participating in the next beat.
- exp_ready  out  1  expectation FIFO not full.
- out_valid  out  1  assembled beat valid.
- out_mask  out  N  lanes carrying data in this beat.
- out_data_vec  out  W*N  lane i data at [i*W +: W]; lanes outside mask are zero.
- out_seq  out  SEQ_W  sequence number of this beat.
- out_ready  in  1  downstream accept.
- err_seq  out  1  sticky sequence-mismatch flag.
- err_lane  out  N  sticky per-lane mismatch bits.

## Operation
- Lane FIFO i pushes on net_valid_vec[i] && net_ready_vec[i], where net_ready_vec[i] = !full_i.
  - Ready does not depend on valid.
- Expectation FIFO pushes on exp_valid && exp_ready.
- cur_seq register resets to 0 and increments modulo 2^SEQ_W on every beat load.
- Beat complete when the expectation head is valid and, for every lane i set in the head mask, lane FIFO i is non-empty.
- Load occurs when the beat is complete and (!out_valid || out_ready). On load:
  - pop the expectation FIFO and every masked lane FIFO;
  - register out_mask, zero-filled data, and out_seq = cur_seq;
  - set out_valid.
- Without a load, out_valid clears when out_valid && out_ready.
- Head mask of 0 completes immediately: it emits an empty beat and consumes a sequence number.
- Data in a lane not named by the head mask stays queued; it is never dropped or reordered.
- Full lane FIFO: backpressure via net_ready low only; no loss.

## Timing
- All outputs reset to 0, including err_seq and err_lane. All FIFOs are flushed and cur_seq is 0.
- Reset assertion mid-operation discards all buffered lanes, expectations, and the held beat immediately.
- Latency: if the last required lane or expectation push occurs in cycle c, out_valid is asserted in cycle c+2.
- Throughput is one beat per cycle while out_ready stays high and inputs keep up.
- A lane push and a pop on the same FIFO in the same cycle are both honoured; occupancy is unchanged.
  - A full FIFO still reports ready low that cycle (no bypass).
- out_* outputs remain stable while out_valid && !out_ready.

## Configuration
- BUTTERFLY_GATHER_SEQ_CHECK_EN defined:
  - on each load, every masked lane's head seq is compared with cur_seq;
  - a mismatch sets err_lane[i] and err_seq (sticky until reset);
  - the beat is still emitted and consumed, so there is no stall.
- Undefined: the seq field is ignored, the comparators are absent, and err_seq and err_lane are tied to 0.
- out_seq is present in both builds.

## Structure
- Shared package holds:
  - lane count and derived widths (N, payload width);
  - the {seq, data} packing offsets;
  - the modulo-increment helper for sequence numbers.
- One sub-module, gather_lane_fifo: synchronous FIFO with full/empty, reused for the N lanes and for the expectation queue (width parameterised).

## Test plan
- N=8, W=8, SEQ_W=4. Push exp_mask=8'hFF, then lanes 0..7 with data 8'h10+i, seq 0, in reverse lane order over 8 cycles. Required: a single beat with out_mask=FF, lane i data 10+i, out_seq=0, asserted 2 cycles after the lane 0 push.
- Push exp masks 8'h01 then 8'h03. Lane 1 data arrives before lane 0's two entries. Required: beat0 carries only lane0's first entry and beat1 carries lanes 0 and 1 (seq 0 then 1); the lane 1 entry is held until beat1.
- Push exp mask 8'h00. Required: an empty beat with out_seq=0 at c+2, and cur_seq advances to 1.
- Hold out_ready=0 while pushing 5 items into lane 3 with LANE_DEPTH=4. Required: net_ready_vec[3] drops after the 4th push, no data is lost, and the output holds stable.
- With the macro defined, push lane 2 with seq 5 against expected seq 0. Required: the beat is emitted, and err_lane=8'h04 and err_seq=1 persist until rst_n is asserted.
- Assert rst_n low mid-stream with 3 entries queued. Required: all outputs are 0 immediately, and after release the next beat reports out_seq=0.
